pixel_uart_tx: RTL and testbench
================================

Name: pixel_uart_tx

Overview:
Serialises processed RGB pixels onto a UART line back to the host PC.
- Input side: the same registered ready/data pixel interface that the post-processing stage drives.
- Pixels are buffered in an internal FIFO. Each pixel goes out as three 8N1 bytes: channel 2 first, then channel 1, then channel 0.
- Position: last block of the processing pipeline, between post-processing and the board UART TX pin.

Parameters:
COLOR_CHANNEL, 8, bits per colour channel; legal range 1..8; each channel is zero-extended to 8 bits on the wire.
CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
FIFO_DEPTH, 16, pixel entries in the FIFO; power of two, minimum 2.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset_n  input  1  synchronous active-low reset.
i_data_ready  input  1  one-cycle strobe; i_data is valid this cycle.
i_data  input  [2:0][COLOR_CHANNEL-1:0]  pixel, three channels.
o_tx  output  1  UART serial line; idles high.
o_busy  output  1  high while any frame bit is on the line or the FIFO is non-empty.
o_fifo_empty  output  1  FIFO holds no pixels.
o_overflow  output  1  sticky flag: a pixel was dropped because the FIFO was full.

Behaviour:
Reset:
- Applies only on a rising i_clk edge with i_reset_n low, regardless of state, including mid-byte.
- Result: o_tx=1, o_busy=0, o_fifo_empty=1, o_overflow=0, FIFO pointers and count=0, FSM in IDLE, baud and bit counters=0.
- Any in-flight byte is abandoned. The line returns high on the next cycle.

FIFO write:
- On a cycle with i_data_ready=1, the pixel is written if count<FIFO_DEPTH, or if a pop occurs in the same cycle (count then unchanged).
- Otherwise the pixel is discarded and o_overflow is set to 1. o_overflow clears only on reset.

FIFO read (pop):
- Occurs only in IDLE when count>0. The popped pixel is latched into a 24-bit shift holding register.

FSM states: IDLE, START, DATA, STOP.
- IDLE: o_tx=1. If FIFO non-empty: pop, set byte index=0, go to START next cycle.
- START: o_tx=0 for exactly CLK_DIV cycles, then go to DATA with bit index=0.
- DATA: o_tx = bit[bit index] of the current byte, LSB first; each bit held for CLK_DIV cycles. After bit 7, go to STOP.
- STOP: o_tx=1 for CLK_DIV cycles.
  - If byte index<2: increment it, go directly to START with no gap.
  - If byte index=2: go to IDLE.

Byte order and timing:
- Byte n = zero-extended i_data[2-n].
- Pixel frame = 30*CLK_DIV cycles.
- Back-to-back pixels have exactly one extra idle-high cycle (the IDLE pop cycle) between them.

Latency and outputs:
- Strobe at edge N into an empty, idle block: the pixel is in the FIFO after edge N and popped at edge N+1. o_tx falls (start bit) after edge N+2.
- o_tx is driven from a register; it never glitches.
- o_fifo_empty is registered from count and reflects the post-edge count.
- o_busy = (state!=IDLE) or (count>0).

Arithmetic:
- Baud counter counts 0..CLK_DIV-1 and wraps.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Count width is clog2(FIFO_DEPTH)+1 so that count=FIFO_DEPTH is representable.

Other rules:
- i_data_ready may assert on any cycle, including consecutive cycles; there is no backpressure output.
- i_data is ignored when i_data_ready=0.

Test Plan:
1. Single pixel: CLK_DIV=4, reset, strobe i_data={8'hA5,8'h3C,8'h0F}. Required response:
   - o_tx low 2 cycles after the strobe.
   - Decoded bytes A5, 3C, 0F.
   - Each frame is 40 cycles with stop bits high.
   - o_busy falls after 120+ cycles, o_fifo_empty=1, o_overflow=0.
2. Back-to-back: strobe 3 pixels on consecutive cycles. Required response:
   - 9 bytes in order ch2, ch1, ch0 per pixel.
   - Exactly 1 idle-high cycle between pixels, none between bytes of the same pixel.
3. Overflow: FIFO_DEPTH=4, strobe 7 pixels on consecutive cycles while the first byte is transmitting. Required response:
   - Pixels 1-5 are transmitted (one popped immediately plus 4 buffered).
   - Pixels 6-7 are dropped.
   - o_overflow rises on the pixel-6 cycle and stays high until reset.
4. Push with pop at full: fill the FIFO to 4, then strobe exactly on the IDLE pop cycle. Required response:
   - The pixel is accepted, count stays 4, o_overflow stays 0.
5. Reset mid-byte: assert i_reset_n=0 for 1 cycle during DATA bit 3. Required response:
   - After the edge: o_tx=1, o_busy=0, o_fifo_empty=1.
   - A new pixel strobed afterwards transmits correctly.
6. COLOR_CHANNEL=5: strobe channel values 5'h1F, 5'h10, 5'h01. Required response:
   - Bytes on the wire are 8'h1F, 8'h10, 8'h01; upper 3 data bits are always 0.

Source files
------------

// File: rtl/pixel_uart_tx.sv
// -----------------------------------------------------------------------------
// pixel_uart_tx
//   Buffers RGB pixels in a small FIFO and serialises each one onto a UART
//   line as three 8N1 bytes, channel 2 first, then channel 1, then channel 0.
//   Channels narrower than 8 bits are zero-extended on the wire.
//
// Ports
//   i_clk         system clock, all logic on the rising edge
//   i_reset_n     synchronous active-low reset
//   i_data_ready  one-cycle strobe, i_data valid this cycle
//   i_data        pixel, three channels of COLOR_CHANNEL bits
//   o_tx          UART serial line, idles high, registered
//   o_busy        frame on the line or pixels still buffered
//   o_fifo_empty  FIFO holds no pixels (registered)
//   o_overflow    sticky: a pixel was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module pixel_uart_tx #(
  parameter int COLOR_CHANNEL = 8,
  parameter int CLK_DIV       = 434,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_data_ready,
  input  logic [2:0][COLOR_CHANNEL-1:0] i_data,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_fifo_empty,
  output logic                          o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0][COLOR_CHANNEL-1:0] mem_q [FIFO_DEPTH];

  state_e        state_q,    state_d;
  logic [BW-1:0] baud_q,     baud_d;
  logic [2:0]    bit_q,      bit_d;
  logic [1:0]    byte_q,     byte_d;
  logic [23:0]   shift_q,    shift_d;
  logic          tx_q,       tx_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          empty_q,    empty_d;
  logic          overflow_q, overflow_d;

  logic pop;
  logic push;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  // A full FIFO still accepts a pixel when a pop frees a slot in the same cycle.
  always_comb begin
    push       = i_data_ready && ((count_q < FIFO_FULL) || pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (i_data_ready && !push);
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          byte_d  = '0;
          bit_d   = '0;
          // Byte 0 (channel 2) sits in the low lane; later bytes shift down.
          shift_d = {8'(mem_q[rd_ptr_q][0]),
                     8'(mem_q[rd_ptr_q][1]),
                     8'(mem_q[rd_ptr_q][2])};
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        tx_d = shift_q[bit_q];
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (byte_q != 2'd2) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[23:8]};
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  // o_tx is registered from the current state's line level, so the line lags
  // the FSM by one cycle and can never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != IDLE) || (count_q != '0);
  assign o_fifo_empty = empty_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_pixel_uart_tx
//   Directed bench for pixel_uart_tx. Two instances share clock and reset:
//   an 8-bit-channel unit and a 5-bit-channel unit, both with CLK_DIV=4 and
//   FIFO_DEPTH=4. Expected bytes are queued when pixels are driven and a UART
//   decoder on the selected line pops and compares them. Frame start times
//   are logged to verify byte spacing and inter-pixel gaps.
// -----------------------------------------------------------------------------
module tb_pixel_uart_tx;

  localparam int BIT_CYC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rdy8 = 1'b0;
  logic [2:0][7:0] d8 = '0;
  logic            rdy5 = 1'b0;
  logic [2:0][4:0] d5 = '0;

  logic tx8, busy8, empty8, ovf8;
  logic tx5, busy5, empty5, ovf5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         sel = 1'b0;   // 0: monitor the 8-bit unit, 1: the 5-bit unit
  logic [7:0] sb [$];       // expected bytes in wire order
  int         starts [$];   // cycle at which each start bit was first seen
  int         mon_cnt = -1;
  logic [7:0] mon_byte;
  logic       mon_tx;
  logic       mon_busy;

  pixel_uart_tx #(.COLOR_CHANNEL(8), .CLK_DIV(BIT_CYC), .FIFO_DEPTH(4)) u_dut8 (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data_ready (rdy8),
    .i_data       (d8),
    .o_tx         (tx8),
    .o_busy       (busy8),
    .o_fifo_empty (empty8),
    .o_overflow   (ovf8)
  );

  pixel_uart_tx #(.COLOR_CHANNEL(5), .CLK_DIV(BIT_CYC), .FIFO_DEPTH(4)) u_dut5 (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data_ready (rdy5),
    .i_data       (d5),
    .o_tx         (tx5),
    .o_busy       (busy5),
    .o_fifo_empty (empty5),
    .o_overflow   (ovf5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mon_tx   = sel ? tx5 : tx8;
  assign mon_busy = sel ? busy5 : busy8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART decoder: samples on the falling clock edge, mid-bit.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt = -1;
    end else if (mon_cnt < 0) begin
      if (mon_tx == 1'b0) begin
        mon_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        check("start_bit", 32'(mon_tx), 32'd0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % BIT_CYC) == 2) begin
        mon_byte = {mon_tx, mon_byte[7:1]};
      end else if (mon_cnt == 38) begin
        check("stop_bit", 32'(mon_tx), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_byte", 32'(mon_byte), 32'h100);
        end else begin
          check("byte", 32'(mon_byte), 32'(sb.pop_front()));
        end
      end
      if (mon_cnt == 39) mon_cnt = -1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    starts.delete();
    @(negedge clk);
  endtask

  // Call at a falling edge; returns at the next falling edge.
  task automatic drive8(input logic [23:0] px, input bit accept);
    d8   = px;
    rdy8 = 1'b1;
    if (accept) begin
      sb.push_back(px[23:16]);
      sb.push_back(px[15:8]);
      sb.push_back(px[7:0]);
    end
    @(negedge clk);
    rdy8 = 1'b0;
  endtask

  task automatic drive5(input logic [4:0] c2, input logic [4:0] c1, input logic [4:0] c0);
    d5   = {c2, c1, c0};
    rdy5 = 1'b1;
    sb.push_back({3'b000, c2});
    sb.push_back({3'b000, c1});
    sb.push_back({3'b000, c0});
    @(negedge clk);
    rdy5 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0 && mon_cnt < 0 && !mon_busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  // Bytes of one pixel are 40 cycles apart; consecutive pixels are 41 apart.
  task automatic check_frames(input string tag, input int pixels);
    check({tag, "_frames"}, 32'(starts.size()), 32'(pixels * 3));
    for (int i = 0; i + 1 < starts.size(); i++) begin
      check({tag, "_gap"}, 32'(starts[i+1] - starts[i]), (i % 3 == 2) ? 32'd41 : 32'd40);
    end
  endtask

  initial begin
    int t0;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_tx8",    32'(tx8),    32'd1);
    check("rst_busy8",  32'(busy8),  32'd0);
    check("rst_empty8", 32'(empty8), 32'd1);
    check("rst_ovf8",   32'(ovf8),   32'd0);
    check("rst_tx5",    32'(tx5),    32'd1);
    check("rst_empty5", 32'(empty5), 32'd1);

    // ---------------- 1: single pixel ----------------
    drive8(24'hA5_3C_0F, 1'b1);
    t0 = cyc;
    check("t1_in_fifo", 32'(empty8), 32'd0);
    @(negedge clk);
    check("t1_pop_tx",    32'(tx8),    32'd1);
    check("t1_pop_empty", 32'(empty8), 32'd1);
    check("t1_pop_busy",  32'(busy8),  32'd1);
    @(negedge clk);
    check("t1_start_fall", 32'(tx8), 32'd0);
    for (int i = 0; i < 200 && busy8; i++) @(negedge clk);
    check("t1_busy_len", 32'(cyc - t0), 32'd121);
    wait_idle("t1", 100);
    check_frames("t1", 1);
    check("t1_empty", 32'(empty8), 32'd1);
    check("t1_ovf",   32'(ovf8),   32'd0);

    // ---------------- 2: back-to-back ----------------
    do_reset();
    drive8(24'h11_22_33, 1'b1);
    drive8(24'h80_7F_01, 1'b1);
    drive8(24'hFE_00_C3, 1'b1);
    wait_idle("t2", 600);
    check_frames("t2", 3);

    // ---------------- 3: overflow ----------------
    do_reset();
    drive8(24'h010203, 1'b1);
    drive8(24'h040506, 1'b1);
    drive8(24'h070809, 1'b1);
    drive8(24'h0A0B0C, 1'b1);
    drive8(24'h0D0E0F, 1'b1);
    check("t3_ovf_p5", 32'(ovf8), 32'd0);
    drive8(24'hDEAD00, 1'b0);
    check("t3_ovf_p6", 32'(ovf8), 32'd1);
    drive8(24'hBEEF00, 1'b0);
    wait_idle("t3", 1000);
    check_frames("t3", 5);
    check("t3_ovf_sticky", 32'(ovf8), 32'd1);

    // ---------------- 4: push with pop at full ----------------
    do_reset();
    check("t4_ovf_cleared", 32'(ovf8), 32'd0);
    drive8(24'h100000, 1'b1);
    t0 = cyc;
    drive8(24'h200000, 1'b1);
    drive8(24'h300000, 1'b1);
    drive8(24'h400000, 1'b1);
    drive8(24'h500000, 1'b1);
    for (int i = 0; i < 200 && cyc != t0 + 121; i++) @(negedge clk);
    drive8(24'h6A6B6C, 1'b1);   // lands on the IDLE pop edge
    check("t4_accept_ovf", 32'(ovf8), 32'd0);
    check("t4_not_empty",  32'(empty8), 32'd0);
    drive8(24'h777777, 1'b0);   // FIFO back at 4 with no pop: dropped
    check("t4_full_ovf", 32'(ovf8), 32'd1);
    wait_idle("t4", 1200);
    check_frames("t4", 6);

    // ---------------- 5: reset mid-byte ----------------
    do_reset();
    drive8(24'hFF_FF_FF, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 100 && cyc != t0 + 18; i++) @(negedge clk);
    rst_n = 1'b0;               // sampled during DATA bit 3
    @(negedge clk);
    check("t5_tx",    32'(tx8),    32'd1);
    check("t5_busy",  32'(busy8),  32'd0);
    check("t5_empty", 32'(empty8), 32'd1);
    #1 rst_n = 1'b1;
    sb.delete();
    starts.delete();
    @(negedge clk);
    drive8(24'h5A_C3_96, 1'b1);
    wait_idle("t5", 300);
    check_frames("t5", 1);

    // ---------------- 6: 5-bit channels ----------------
    do_reset();
    sel = 1'b1;
    drive5(5'h1F, 5'h10, 5'h01);
    drive5(5'h0A, 5'h15, 5'h00);
    wait_idle("t6", 600);
    check_frames("t6", 2);
    check("t6_ovf", 32'(ovf5), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
